// File: rtl/register_file_wb.sv
// Architectural register file (R0-R14 stored, R15 reads the PC) with two
// combinational read ports, same-cycle writeback bypass and a per-register
// pending-write scoreboard that raises a hazard for in-flight source operands.
module register_file_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic              chk1,
  input  logic              chk2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_dest,
  input  logic              wb_wb_en,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic [DATA_W-1:0] wb_value,
  output logic              hazard,
  output logic              sb_err
);

  localparam int                NREG    = 15;
  localparam logic [ADDR_W-1:0] PC_IDX  = 4'd15;
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [CNT_W-1:0]  cnt_q  [NREG];
  logic [CNT_W-1:0]  cnt_d  [NREG];
  logic              sb_err_q;
  logic              sb_err_d;
  logic [NREG-1:0]   pend;

  // Read port 1: stored value, overridden by the writeback bypass, then by the PC.
  always_comb begin
    rd_data1 = '0;
    for (int r = 0; r < NREG; r++) begin
      if (rd_addr1 == ADDR_W'(r)) rd_data1 = regs_q[r];
    end
    if (wb_wb_en && wb_dest == rd_addr1) rd_data1 = wb_value;
    if (rd_addr1 == PC_IDX) rd_data1 = pc_in;
  end

  // Read port 2: identical to port 1, fully independent.
  always_comb begin
    rd_data2 = '0;
    for (int r = 0; r < NREG; r++) begin
      if (rd_addr2 == ADDR_W'(r)) rd_data2 = regs_q[r];
    end
    if (wb_wb_en && wb_dest == rd_addr2) rd_data2 = wb_value;
    if (rd_addr2 == PC_IDX) rd_data2 = pc_in;
  end

  // Effective pending: count minus a retiring write this cycle, which the bypass covers.
  always_comb begin
    pend = '0;
    for (int r = 0; r < NREG; r++) begin
      if (wb_wb_en && wb_dest == ADDR_W'(r)) pend[r] = (cnt_q[r] > CNT_W'(1));
      else                                   pend[r] = (cnt_q[r] != '0);
    end
  end

  // Hazard: any enabled source operand still in flight; R15 never matches a tracked index.
  always_comb begin
    hazard = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      if (chk1 && rd_addr1 == ADDR_W'(r) && pend[r]) hazard = 1'b1;
      if (chk2 && rd_addr2 == ADDR_W'(r) && pend[r]) hazard = 1'b1;
    end
  end

  // Next-state for data, scoreboard counters and the sticky error flag.
  always_comb begin
    sb_err_d = sb_err_q;
    for (int r = 0; r < NREG; r++) begin
      logic inc;
      logic dec;
      regs_d[r] = regs_q[r];
      cnt_d[r]  = cnt_q[r];
      inc = issue_en && issue_dest == ADDR_W'(r);
      dec = wb_wb_en && wb_dest == ADDR_W'(r);
      if (dec) regs_d[r] = wb_value;
      if (inc && !dec) begin
        if (cnt_q[r] == CNT_MAX) sb_err_d = 1'b1;
        else                     cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (dec && !inc) begin
        // Retiring an untracked write is an error, but the data still lands.
        if (cnt_q[r] == '0) sb_err_d = 1'b1;
        else                cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end
  end

  // State registers; reset discards all data and in-flight tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= regs_d[r];
        cnt_q[r]  <= cnt_d[r];
      end
      sb_err_q <= sb_err_d;
    end
  end

  assign sb_err = sb_err_q;

endmodule

// File: tb/tb_register_file_wb.sv
// Directed bench for register_file_wb: reset state, scoreboard hazards,
// bypass, R15 handling, saturation/underflow errors and async reset.
module tb_register_file_wb;

  logic        clk;
  logic        rst;
  logic [3:0]  rd_addr1, rd_addr2;
  logic        chk1, chk2;
  logic [31:0] rd_data1, rd_data2;
  logic [31:0] pc_in;
  logic        issue_en;
  logic [3:0]  issue_dest;
  logic        wb_wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;
  logic        hazard;
  logic        sb_err;

  int checks;
  int failures;

  register_file_wb dut (
    .clk        (clk),
    .rst        (rst),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .chk1       (chk1),
    .chk2       (chk2),
    .rd_data1   (rd_data1),
    .rd_data2   (rd_data2),
    .pc_in      (pc_in),
    .issue_en   (issue_en),
    .issue_dest (issue_dest),
    .wb_wb_en   (wb_wb_en),
    .wb_dest    (wb_dest),
    .wb_value   (wb_value),
    .hazard     (hazard),
    .sb_err     (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are changed 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_en = 1'b0; issue_dest = 4'd0;
    wb_wb_en = 1'b0; wb_dest = 4'd0; wb_value = 32'h0;
    chk1 = 1'b0; chk2 = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0;
    pc_in = 32'h0000_1008;
    rd_addr1 = 4'd0;
    rd_addr2 = 4'd0;
    idle();
    tick();
    rst = 1'b1;
    #1;

    // Reset state of every address on both ports.
    for (int a = 0; a < 16; a++) begin
      rd_addr1 = 4'(a);
      rd_addr2 = 4'(15 - a);
      chk1 = 1'b1; chk2 = 1'b1;
      #1;
      check("rst_rd1", rd_data1, (a == 15) ? 32'h0000_1008 : 32'h0);
      check("rst_rd2", rd_data2, (a == 0)  ? 32'h0000_1008 : 32'h0);
      check("rst_hazard", hazard, 0);
    end
    check("rst_sb_err", sb_err, 0);
    idle();

    // Single issue to R3, hazard until WB cycle, bypass then stored value.
    issue_en = 1'b1; issue_dest = 4'd3;
    tick();
    idle(); chk1 = 1'b1; rd_addr1 = 4'd3; #1;
    check("r3_haz_c1", hazard, 1);
    tick(); #1;
    check("r3_haz_c2", hazard, 1);
    tick();
    wb_wb_en = 1'b1; wb_dest = 4'd3; wb_value = 32'hDEAD_BEEF; #1;
    check("r3_haz_c3", hazard, 0);
    check("r3_bypass", rd_data1, 32'hDEAD_BEEF);
    tick();
    wb_wb_en = 1'b0; wb_value = 32'h0; #1;
    check("r3_stored", rd_data1, 32'hDEAD_BEEF);
    check("r3_haz_c4", hazard, 0);

    // Two issues to R5, retire one, issue+WB together, retire the last.
    idle(); issue_en = 1'b1; issue_dest = 4'd5;
    tick(); tick();
    idle(); chk2 = 1'b1; rd_addr2 = 4'd5;
    wb_wb_en = 1'b1; wb_dest = 4'd5; wb_value = 32'h55; #1;
    check("r5_haz_wb1", hazard, 1);
    check("r5_bypass1", rd_data2, 32'h55);
    tick();
    wb_wb_en = 1'b0; #1;
    check("r5_haz_cnt1", hazard, 1);
    issue_en = 1'b1; issue_dest = 4'd5;
    wb_wb_en = 1'b1; wb_dest = 4'd5; wb_value = 32'h66; #1;
    check("r5_haz_both", hazard, 0);
    tick();
    issue_en = 1'b0; wb_wb_en = 1'b0; #1;
    check("r5_haz_after_both", hazard, 1);
    check("r5_val_66", rd_data2, 32'h66);
    wb_wb_en = 1'b1; wb_dest = 4'd5; wb_value = 32'h77; #1;
    check("r5_haz_wb2", hazard, 0);
    tick();
    idle(); chk2 = 1'b1; #1;
    check("r5_haz_done", hazard, 0);
    check("r5_val_77", rd_data2, 32'h77);
    check("r5_sb_err", sb_err, 0);

    // WB and issue to R15 leave everything untouched.
    idle();
    rd_addr1 = 4'd15; chk1 = 1'b1;
    issue_en = 1'b1; issue_dest = 4'd15;
    wb_wb_en = 1'b1; wb_dest = 4'd15; wb_value = 32'h1234; #1;
    check("r15_rd_during", rd_data1, 32'h0000_1008);
    check("r15_haz_during", hazard, 0);
    tick();
    idle(); chk1 = 1'b1; chk2 = 1'b1; rd_addr1 = 4'd15; rd_addr2 = 4'd15; #1;
    check("r15_rd_after", rd_data1, 32'h0000_1008);
    check("r15_haz_after", hazard, 0);
    check("r15_sb_err", sb_err, 0);
    rd_addr1 = 4'd3; rd_addr2 = 4'd0; #1;
    check("r15_r3_kept", rd_data1, 32'hDEAD_BEEF);
    check("r15_r0_kept", rd_data2, 32'h0);
    check("r15_haz_r3r0", hazard, 0);
    rd_addr1 = 4'd5; #1;
    check("r15_r5_kept", rd_data1, 32'h77);

    // Saturation: four issues to R1.
    idle(); issue_en = 1'b1; issue_dest = 4'd1;
    tick(); tick(); tick();
    #1;
    check("sat_no_err_3", sb_err, 0);
    tick();
    idle(); chk1 = 1'b1; rd_addr1 = 4'd1; #1;
    check("sat_err_4", sb_err, 1);
    check("sat_haz", hazard, 1);

    // Underflow: WB to R2 straight after reset.
    do_reset();
    check("uf_rst_err", sb_err, 0);
    chk1 = 1'b1; rd_addr1 = 4'd1; #1;
    check("uf_rst_haz", hazard, 0);
    wb_wb_en = 1'b1; wb_dest = 4'd2; wb_value = 32'hA5A5; #1;
    check("uf_no_err_yet", sb_err, 0);
    tick();
    idle(); rd_addr1 = 4'd2; #1;
    check("uf_r2_written", rd_data1, 32'hA5A5);
    check("uf_err", sb_err, 1);

    // Async reset mid-cycle with pending count and nonzero registers.
    idle(); issue_en = 1'b1; issue_dest = 4'd7;
    wb_wb_en = 1'b1; wb_dest = 4'd8; wb_value = 32'hCAFE;
    tick();
    idle(); chk1 = 1'b1; rd_addr1 = 4'd7; rd_addr2 = 4'd8; #1;
    check("ar_pre_haz", hazard, 1);
    check("ar_pre_r8", rd_data2, 32'hCAFE);
    #1;
    rst = 1'b0;
    #1;
    check("ar_haz", hazard, 0);
    check("ar_sb_err", sb_err, 0);
    check("ar_r8", rd_data2, 32'h0);
    check("ar_r2", (rd_addr1 == 4'd7) ? rd_data1 : 32'hFFFF_FFFF, 32'h0);
    rd_addr1 = 4'd15; rd_addr2 = 4'd3; #1;
    check("ar_r15", rd_data1, 32'h0000_1008);
    check("ar_r3", rd_data2, 32'h0);
    tick();
    rst = 1'b1;
    #1;
    rd_addr1 = 4'd7; #1;
    check("ar_post_haz", hazard, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_file_wb.md
Name: register_file_wb

Overview:
- Architectural register file for the ARM pipeline, i.e. the write-side consumer of the writeback stage's (WB_Dest, WB_Value, WB_WB_EN) bundle.
- Provides two combinational read ports for ID, with same-cycle write bypass.
- Contains a per-register pending-write scoreboard: ID marks a destination at issue, WB retires it, and a hazard output stalls ID while a source operand is still in flight.

Parameters:
- DATA_W, 32, register width.
- ADDR_W, 4, register index width (R0–R15).
- CNT_W, 2, per-register in-flight counter width; max 3 outstanding writes per register.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- rd_addr1  input  ADDR_W  read port 1 index (Rn).
- rd_addr2  input  ADDR_W  read port 2 index (Rm/Rd for store).
- chk1  input  1  read port 1 operand is actually used (hazard check enable).
- chk2  input  1  read port 2 operand is actually used.
- rd_data1  output  DATA_W  read port 1 data.
- rd_data2  output  DATA_W  read port 2 data.
- pc_in  input  DATA_W  value returned for reads of R15.
- issue_en  input  1  ID issues an instruction with writeback this cycle (already gated by stall).
- issue_dest  input  ADDR_W  destination of the issuing instruction.
- wb_wb_en  input  1  writeback valid.
- wb_dest  input  ADDR_W  writeback destination.
- wb_value  input  DATA_W  writeback data.
- hazard  output  1  stall request to ID.
- sb_err  output  1  sticky scoreboard error.

Behaviour:
- Storage: R0–R14 are DATA_W flops. R15 is not stored.
- Reads: combinational.
  - Address 15 returns pc_in.
  - Otherwise, if wb_wb_en && wb_dest==addr, returns wb_value (bypass).
  - Otherwise returns the stored value.
  - Ports are fully independent; both may hit the bypass in the same cycle.
- Write: on posedge clk, if wb_wb_en && wb_dest!=15, the register takes wb_value. Writes to 15 are ignored (branches are handled elsewhere).
- Scoreboard counters: cnt[r] for r in 0..14. Index 15 is never tracked; issue or WB to 15 leaves every counter untouched. Per posedge, for each r:
  - inc = issue_en && issue_dest==r
  - dec = wb_wb_en && wb_dest==r
  - inc && dec: cnt unchanged.
  - inc only: if cnt==max (3), cnt holds and sb_err sets; else cnt+1.
  - dec only: if cnt==0, cnt holds, sb_err sets, and the data write still occurs; else cnt−1.
- Effective pending: pend(r) = cnt[r] − (wb_wb_en && wb_dest==r) > 0, evaluated combinationally. A value being written this cycle is covered by the bypass and does not cause a stall.
- hazard = (chk1 && rd_addr1!=15 && pend(rd_addr1)) || (chk2 && rd_addr2!=15 && pend(rd_addr2)). Purely combinational, no latency.
- Same-cycle issue to a register being read does not affect this cycle's hazard; it counts from the next cycle.
- sb_err: sticky once set; cleared only by reset.
- Reset (rst=0, asynchronous): R0–R14 = 0, all cnt = 0, sb_err = 0.
  - Consequently rd_data* read 0 for addresses 0–14 and pc_in for address 15 (bypass still applies).
  - hazard = 0.
- Reset deassertion mid-operation: all in-flight state is discarded. The pipeline is required to be reset simultaneously.

Test Plan:
- Reset, then read all 16 addresses with pc_in=0x0000_1008 -> 0 for R0–R14, 0x0000_1008 for R15, hazard=0, sb_err=0.
- issue R3 at cycle 0; chk1=1, rd_addr1=3 for cycles 1–3 -> hazard=1 in cycles 1–2; in cycle 3, with wb_wb_en=1, wb_dest=3, wb_value=0xDEADBEEF -> hazard=0 and rd_data1=0xDEADBEEF (bypass); cycle 4 stored value reads 0xDEADBEEF.
- Two issues to R5, then one WB to R5 -> hazard stays 1 until the second WB cycle; same-cycle issue+WB to R5 leaves cnt unchanged.
- WB to R15 with value 0x1234 and issue to R15 -> no register changes, rd_addr1=15 still returns pc_in, hazard=0, sb_err=0.
- Four issues to R1 with no WB -> sb_err=1 after the fourth; separately after reset, a WB to R2 with cnt=0 -> R2 written and sb_err=1.
- Assert rst=0 asynchronously mid-cycle with pending counts and nonzero registers -> immediately all reads 0 (except R15), hazard=0, sb_err=0.
